// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout: reads a 128x120 15-bit framebuffer through a 1-cycle-latency VRAM
// port, replicates each pixel 5x horizontally and 4x vertically, and drives the DAC pins.
module vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned FB_W     = 128,
    parameter int unsigned FB_H     = 120,
    parameter int unsigned SCALE_X  = 5,
    parameter int unsigned SCALE_Y  = 4
) (
    input  logic        vclk,
    input  logic        rst,
    output logic [15:0] vaddr,
    input  logic [15:0] vout,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [4:0]  vga_r,
    output logic [4:0]  vga_g,
    output logic [4:0]  vga_b,
    output logic        vga_de,
    output logic        vblank,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XSW     = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int unsigned YSW     = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_ADV_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ADV_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [XSW-1:0] XSUB_LAST = XSW'(SCALE_X - 1);
    localparam logic [YSW-1:0] YSUB_LAST = YSW'(SCALE_Y - 1);
    localparam logic [6:0] XPIX_LAST  = 7'(FB_W - 1);
    localparam logic [6:0] YPIX_LAST  = 7'(FB_H - 1);

    logic [9:0]     hcnt, vcnt;
    logic [XSW-1:0] xsub;
    logic [YSW-1:0] ysub;
    logic [6:0]     xpix, ypix;
    logic           h_wrap, v_wrap, x_adv, y_adv;
    logic           active0, hs0, vs0;
    logic           active1, hs1, vs1;
    logic           unused_vout;

    assign unused_vout = vout[15];

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = h_wrap && (vcnt == V_LAST);
    // Stopping one count early leaves the last pixel's address held through blanking.
    assign x_adv  = (hcnt < H_ADV_END);
    assign y_adv  = h_wrap && (vcnt < V_ADV_END);

    assign active0 = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs0     = !((hcnt >= HS_START) && (hcnt < HS_END));
    assign vs0     = !((vcnt >= VS_START) && (vcnt < VS_END));

    assign vaddr       = {2'b00, ypix, xpix};
    assign vblank      = (vcnt >= V_ACT);
    assign frame_start = !rst && (hcnt == 10'd0) && (vcnt == 10'd0);

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
            xsub <= '0;
            xpix <= '0;
            ysub <= '0;
            ypix <= '0;
        end else begin
            hcnt <= h_wrap ? 10'd0 : hcnt + 10'd1;

            if (h_wrap) begin
                xsub <= '0;
                xpix <= '0;
            end else if (x_adv) begin
                if (xsub == XSUB_LAST) begin
                    xsub <= '0;
                    if (xpix != XPIX_LAST) xpix <= xpix + 7'd1;
                end else begin
                    xsub <= xsub + XSW'(1);
                end
            end

            if (h_wrap) vcnt <= v_wrap ? 10'd0 : vcnt + 10'd1;

            if (v_wrap) begin
                ysub <= '0;
                ypix <= '0;
            end else if (y_adv) begin
                if (ysub == YSUB_LAST) begin
                    ysub <= '0;
                    if (ypix != YPIX_LAST) ypix <= ypix + 7'd1;
                end else begin
                    ysub <= ysub + YSW'(1);
                end
            end
        end
    end

    // Stage 1 lines timing up with the registered VRAM read; stage 2 drives the pins.
    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            active1 <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_de  <= 1'b0;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
        end else begin
            active1 <= active0;
            hs1     <= hs0;
            vs1     <= vs0;
            vga_hs  <= hs1;
            vga_vs  <= vs1;
            vga_de  <= active1;
            vga_r   <= active1 ? vout[14:10] : 5'd0;
            vga_g   <= active1 ? vout[9:5]   : 5'd0;
            vga_b   <= active1 ? vout[4:0]   : 5'd0;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a full-size instance plus one with a shortened vertical
// geometry so that vsync, vblank and frame wrap are reached within a short run.
module tb_vga_scanout;

    localparam int SV_ACT  = 32;
    localparam int SV_FP   = 2;
    localparam int SV_SYNC = 2;
    localparam int SV_BP   = 3;
    localparam int SFB_H   = 8;

    typedef struct {
        int          inst;
        int          due;
        bit          stage0;
        bit          chk_vaddr;
        logic [15:0] vaddr;
        logic [15:0] vaddr_max;
        logic        vblank;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
        logic [4:0]  r;
        logic [4:0]  g;
        logic [4:0]  b;
    } exp_t;

    logic        vclk;
    logic        rst_dut     [2];
    logic [15:0] vaddr       [2];
    logic [15:0] vout        [2];
    logic        vga_hs      [2];
    logic        vga_vs      [2];
    logic [4:0]  vga_r       [2];
    logic [4:0]  vga_g       [2];
    logic [4:0]  vga_b       [2];
    logic        vga_de      [2];
    logic        vblank      [2];
    logic        frame_start [2];

    logic [15:0] vram [16384];
    exp_t        q[$];
    int          t [2];
    int          cyc;
    int          checks;
    int          errors;

    vga_scanout u_full (
        .vclk        (vclk),
        .rst         (rst_dut[0]),
        .vaddr       (vaddr[0]),
        .vout        (vout[0]),
        .vga_hs      (vga_hs[0]),
        .vga_vs      (vga_vs[0]),
        .vga_r       (vga_r[0]),
        .vga_g       (vga_g[0]),
        .vga_b       (vga_b[0]),
        .vga_de      (vga_de[0]),
        .vblank      (vblank[0]),
        .frame_start (frame_start[0])
    );

    vga_scanout #(
        .V_ACTIVE (SV_ACT),
        .V_FP     (SV_FP),
        .V_SYNC   (SV_SYNC),
        .V_BP     (SV_BP),
        .FB_H     (SFB_H)
    ) u_short (
        .vclk        (vclk),
        .rst         (rst_dut[1]),
        .vaddr       (vaddr[1]),
        .vout        (vout[1]),
        .vga_hs      (vga_hs[1]),
        .vga_vs      (vga_vs[1]),
        .vga_r       (vga_r[1]),
        .vga_g       (vga_g[1]),
        .vga_b       (vga_b[1]),
        .vga_de      (vga_de[1]),
        .vblank      (vblank[1]),
        .frame_start (frame_start[1])
    );

    initial begin
        vclk = 1'b0;
        forever #20 vclk = ~vclk;
    end

    // VRAM read port: address registered, data one cycle later.
    initial begin
        vout[0] = '0;
        vout[1] = '0;
    end
    always @(posedge vclk) begin
        vout[0] <= vram[vaddr[0][13:0]];
        vout[1] <= vram[vaddr[1][13:0]];
    end

    always @(posedge vclk) cyc <= cyc + 1;

    function automatic exp_t exp_reset(int i, int due, bit stage0);
        exp_t e;
        e.inst      = i;
        e.due       = due;
        e.stage0    = stage0;
        e.chk_vaddr = 1'b1;
        e.vaddr     = 16'd0;
        e.vaddr_max = (i == 0) ? 16'd15359 : 16'(SFB_H * 128 - 1);
        e.vblank    = 1'b0;
        e.fs        = 1'b0;
        e.hs        = 1'b1;
        e.vs        = 1'b1;
        e.de        = 1'b0;
        e.r         = 5'd0;
        e.g         = 5'd0;
        e.b         = 5'd0;
        return e;
    endfunction

    // Reference: position from elapsed cycles, pixel from plain division of the screen position.
    function automatic exp_t exp_at(int i, int due, int tt, bit stage0);
        exp_t        e;
        int          vact, vfp, vsync, vtot, fbh, h, v, addr;
        bit          act;
        logic [15:0] pix;
        vact  = (i == 0) ? 480 : SV_ACT;
        vfp   = (i == 0) ? 10  : SV_FP;
        vsync = (i == 0) ? 2   : SV_SYNC;
        vtot  = (i == 0) ? 525 : SV_ACT + SV_FP + SV_SYNC + SV_BP;
        fbh   = (i == 0) ? 120 : SFB_H;
        h     = tt % 800;
        v     = (tt / 800) % vtot;
        act   = (h < 640) && (v < vact);
        addr  = (v / 4) * 128 + h / 5;
        pix   = act ? vram[addr] : 16'd0;
        e.inst      = i;
        e.due       = due;
        e.stage0    = stage0;
        e.chk_vaddr = act;
        e.vaddr     = 16'(addr);
        e.vaddr_max = 16'(fbh * 128 - 1);
        e.vblank    = (v >= vact);
        e.fs        = (h == 0) && (v == 0);
        e.hs        = !((h >= 656) && (h < 752));
        e.vs        = !((v >= vact + vfp) && (v < vact + vfp + vsync));
        e.de        = act;
        e.r         = pix[14:10];
        e.g         = pix[9:5];
        e.b         = pix[4:0];
        return e;
    endfunction

    // Issuer: pushes what each instance must show now (stage 0) and two cycles on (pins).
    always @(negedge vclk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_dut[i]) begin
                for (int k = int'(q.size()) - 1; k >= 0; k--)
                    if (q[k].inst == i) q.delete(k);
                t[i] = -1;
                q.push_back(exp_reset(i, cyc, 1'b1));
                q.push_back(exp_reset(i, cyc, 1'b0));
            end else begin
                t[i] = t[i] + 1;
                q.push_back(exp_at(i, cyc, t[i], 1'b1));
                q.push_back(exp_at(i, cyc + 2, t[i], 1'b0));
                if (t[i] < 2) q.push_back(exp_reset(i, cyc, 1'b0));
            end
        end
    end

    task automatic check(string name, int i, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, req);
        end
    endtask

    // Monitor: compares every expectation that has come due against the live outputs.
    always @(negedge vclk) begin
        #1;
        for (int k = int'(q.size()) - 1; k >= 0; k--) begin
            if (q[k].due <= cyc) begin
                exp_t e;
                int   i;
                e = q[k];
                i = e.inst;
                q.delete(k);
                check("due", i, 32'(e.due), 32'(cyc));
                if (e.stage0) begin
                    if (e.chk_vaddr) check("vaddr", i, 32'(vaddr[i]), 32'(e.vaddr));
                    check("vaddr_range", i, 32'(vaddr[i] <= e.vaddr_max), 32'd1);
                    check("vblank", i, 32'(vblank[i]), 32'(e.vblank));
                    check("frame_start", i, 32'(frame_start[i]), 32'(e.fs));
                end else begin
                    check("vga_hs", i, 32'(vga_hs[i]), 32'(e.hs));
                    check("vga_vs", i, 32'(vga_vs[i]), 32'(e.vs));
                    check("vga_de", i, 32'(vga_de[i]), 32'(e.de));
                    check("vga_r", i, 32'(vga_r[i]), 32'(e.r));
                    check("vga_g", i, 32'(vga_g[i]), 32'(e.g));
                    check("vga_b", i, 32'(vga_b[i]), 32'(e.b));
                end
            end
        end
    end

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        t[0]       = -1;
        t[1]       = -1;
        rst_dut[0] = 1'b1;
        rst_dut[1] = 1'b1;
        for (int k = 0; k < 16384; k++) vram[k] = 16'($urandom);
        vram[0] = 16'h7C00;
        vram[1] = 16'h03E0;

        repeat (4) @(posedge vclk);
        #5;
        rst_dut[0] = 1'b0;
        rst_dut[1] = 1'b0;

        // Short instance reset mid-frame at line 20, pixel 300, held 3 clocks.
        repeat (16300) @(posedge vclk);
        #5 rst_dut[1] = 1'b1;
        repeat (3) @(posedge vclk);
        #5 rst_dut[1] = 1'b0;

        // Full instance reset at a random point for a random short time.
        repeat (5000 + $urandom_range(0, 799)) @(posedge vclk);
        #5 rst_dut[0] = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge vclk);
        #5 rst_dut[0] = 1'b0;

        // Long enough for the short instance to complete a whole frame and wrap.
        repeat (28500) @(posedge vclk);
        @(negedge vclk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
